// File: rtl/detect_58_serializer_if.sv
// Parallel-in / serial-out handshake bundle between a word source,
// the serializer and the downstream 0x58 detector.
interface detect_58_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             stall;
    logic             bit_out;
    logic             bit_valid;
    logic             last_bit;
    logic             busy;

    // Word source / downstream side.
    modport master (
        output data_in, valid_in, stall,
        input  ready_out, bit_out, bit_valid, last_bit, busy
    );

    // Serializer side.
    modport slave (
        input  data_in, valid_in, stall,
        output ready_out, bit_out, bit_valid, last_bit, busy
    );
endinterface

// File: rtl/detect_58_serializer.sv
// Upstream feeder for the 0x58 sequence detector: accepts parallel words over
// valid/ready and shifts them out one bit per cycle, back-to-back when the
// source keeps up, frozen while the downstream stalls.
module detect_58_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    detect_58_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;

    logic w_shift;
    logic w_last;
    logic w_ready;
    logic w_accept;
    logic w_consume;

    // Handshake decode and next-state selection.
    always_comb begin
        w_shift   = (r_state == S_SHIFT);
        w_last    = w_shift && (r_cnt == '0);
        // A new word may enter only when idle or as the final bit leaves,
        // so the shift register is never overwritten mid-word.
        w_ready   = (r_state == S_IDLE) || (w_last && !bus.stall);
        w_accept  = bus.valid_in && w_ready;
        w_consume = w_shift && !bus.stall;

        w_next = r_state;
        if (w_accept) begin
            w_next = S_SHIFT;
        end else if (w_consume && w_last) begin
            w_next = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shift register and remaining-bit counter; both hold under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shreg <= bus.data_in;
            r_cnt   <= CNT_LOAD;
        end else if (w_consume && !w_last) begin
            if (MSB_FIRST) begin
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end else begin
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
            end
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Outputs are decoded from registered state, so they hold during stall.
    always_comb begin
        bus.ready_out = w_ready;
        bus.bit_valid = w_shift;
        bus.busy      = w_shift;
        bus.last_bit  = w_last;
        if (w_shift) begin
            bus.bit_out = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
        end else begin
            bus.bit_out = 1'b0;
        end
    end
endmodule
